// File: rtl/full_st0_error_bank_buffer.sv
// Four-bank error sample store with single-bank contiguous replay.
// Optional macro: FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN drops writes into full banks.
// Ports: clk, reset (sync, active-high), load_length, error_valid/value/phase/
// sub_address (write side), rd_start/rd_phase (replay request),
// rd_data/rd_vld/rd_last/rd_busy/rd_miss (replay side), bank_full, error_overflow.
module full_st0_error_bank_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       load_length,
  input  logic             error_valid,
  input  logic [WIDTH-1:0] error_value,
  input  logic [1:0]       error_phase,
  input  logic [AW-1:0]    error_sub_address,
  input  logic             rd_start,
  input  logic [1:0]       rd_phase,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  output logic             rd_last,
  output logic             rd_busy,
  output logic             rd_miss,
  output logic [3:0]       bank_full,
  output logic             error_overflow
);

  typedef enum logic {IDLE, READ} state_t;

  logic [WIDTH-1:0] mem [4*DEPTH];

  state_t        state;
  logic [1:0]    ph;
  logic [AW-1:0] len;
  logic [AW-1:0] addr;
  logic [AW-1:0] ll_aw;
  logic          wr_ok;
  logic          idle_free;
  logic          last_issue;
  logic          start_ok;
  logic          start_miss;
  logic [3:0]    set_m;
  logic [3:0]    clr_m;

  assign ll_aw = AW'(load_length);

  always_comb begin
`ifdef FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN
    wr_ok = error_valid && !bank_full[error_phase];
`else
    wr_ok = error_valid;
`endif
    // A new replay may only start once the previous stream has fully drained.
    idle_free  = (state == IDLE) && !rd_vld;
    last_issue = (state == READ) && (addr == len);
    start_ok   = idle_free && rd_start && bank_full[rd_phase];
    start_miss = idle_free && rd_start && !bank_full[rd_phase];
    set_m = 4'b0000;
    clr_m = 4'b0000;
    if (wr_ok && (error_sub_address == ll_aw))
      set_m[error_phase] = 1'b1;
    if (last_issue)
      clr_m[ph] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{error_phase, error_sub_address}] <= error_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ph             <= 2'd0;
      len            <= '0;
      addr           <= '0;
      rd_data        <= '0;
      rd_vld         <= 1'b0;
      rd_last        <= 1'b0;
      rd_busy        <= 1'b0;
      rd_miss        <= 1'b0;
      bank_full      <= 4'b0000;
      error_overflow <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle set wins.
      bank_full <= (bank_full & ~clr_m) | set_m;
      rd_miss   <= start_miss;
      rd_vld    <= (state == READ);
      rd_last   <= last_issue;
      rd_busy   <= (state == READ) || start_ok;
      if (state == READ)
        rd_data <= mem[{ph, addr}];
`ifdef FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN
      if (error_valid && bank_full[error_phase])
        error_overflow <= 1'b1;
`else
      error_overflow <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            ph    <= rd_phase;
            len   <= ll_aw;
            addr  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (addr == len)
            state <= IDLE;
          else
            addr <= addr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_st0_error_bank_buffer.sv
// Scoreboard bench for full_st0_error_bank_buffer.
// Directed stimulus; a negedge monitor compares replayed words to a queue.
module tb_full_st0_error_bank_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  load_length = 3'd0;
  logic        error_valid = 1'b0;
  logic [31:0] error_value = '0;
  logic [1:0]  error_phase = 2'd0;
  logic [2:0]  error_sub_address = 3'd0;
  logic        rd_start = 1'b0;
  logic [1:0]  rd_phase = 2'd0;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic        rd_last;
  logic        rd_busy;
  logic        rd_miss;
  logic [3:0]  bank_full;
  logic        error_overflow;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  full_st0_error_bank_buffer #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .load_length(load_length),
    .error_valid(error_valid),
    .error_value(error_value),
    .error_phase(error_phase),
    .error_sub_address(error_sub_address),
    .rd_start(rd_start),
    .rd_phase(rd_phase),
    .rd_data(rd_data),
    .rd_vld(rd_vld),
    .rd_last(rd_last),
    .rd_busy(rd_busy),
    .rd_miss(rd_miss),
    .bank_full(bank_full),
    .error_overflow(error_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld got=%h exp=none", rd_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_last", {31'd0, rd_last}, {31'd0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] p, input logic [2:0] s,
                    input logic [31:0] v);
    error_valid = 1'b1;
    error_phase = p;
    error_sub_address = s;
    error_value = v;
    tick();
    error_valid = 1'b0;
  endtask

  task automatic fill(input logic [1:0] p, input int n,
                      input logic [31:0] base);
    for (int i = 0; i < n; i++)
      wr(p, 3'(i), base + 32'(i));
  endtask

  task automatic expect_bank(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      push(base + 32'(i), i == n - 1);
  endtask

  task automatic start(input logic [1:0] p);
    rd_start = 1'b1;
    rd_phase = p;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_last(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rd_last === 1'b1) found = 1'b1;
      else tick();
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (rd_busy === 1'b0 && rd_vld === 1'b0) done = 1'b1;
      else tick();
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("rst_data", rd_data, 32'd0);
    chk("rst_vld", {31'd0, rd_vld}, 32'd0);
    chk("rst_last", {31'd0, rd_last}, 32'd0);
    chk("rst_busy", {31'd0, rd_busy}, 32'd0);
    chk("rst_miss", {31'd0, rd_miss}, 32'd0);
    chk("rst_full", {28'd0, bank_full}, 32'd0);
    chk("rst_ovf", {31'd0, error_overflow}, 32'd0);
    reset = 1'b0;

    // Bank 0, four words.
    load_length = 3'd3;
    fill(2'd0, 3, 32'h10);
    chk("full_partial", {28'd0, bank_full}, 32'h0);
    wr(2'd0, 3'd3, 32'h13);
    chk("full_b0", {28'd0, bank_full}, 32'h1);
    expect_bank(4, 32'h10);
    start(2'd0);
    chk("t1_busy", {31'd0, rd_busy}, 32'd1);
    chk("t1_vld", {31'd0, rd_vld}, 32'd0);
    tick();
    chk("t2_vld", {31'd0, rd_vld}, 32'd1);
    wait_last("last_b0");
    chk("clr_b0", {28'd0, bank_full}, 32'h0);
    chk("busy_on_last", {31'd0, rd_busy}, 32'd1);
    tick();
    wait_idle();

    // Empty bank request.
    start(2'd2);
    chk("miss_pulse", {31'd0, rd_miss}, 32'd1);
    chk("miss_busy", {31'd0, rd_busy}, 32'd0);
    tick();
    chk("miss_clear", {31'd0, rd_miss}, 32'd0);
    chk("miss_novld", {31'd0, rd_vld}, 32'd0);

    // Banks 3 and 1, back-to-back.
    load_length = 3'd7;
    fill(2'd1, 8, 32'h100);
    fill(2'd3, 8, 32'h300);
    chk("full_b13", {28'd0, bank_full}, 32'hA);
    expect_bank(8, 32'h300);
    expect_bank(8, 32'h100);
    start(2'd3);
    rd_start = 1'b1;
    rd_phase = 2'd1;
    tick();
    rd_start = 1'b0;
    chk("ign_read_miss", {31'd0, rd_miss}, 32'd0);
    wait_last("last_b3");
    rd_start = 1'b1;
    rd_phase = 2'd1;
    tick();
    rd_start = 1'b0;
    chk("gap_busy", {31'd0, rd_busy}, 32'd0);
    chk("ign_drain_miss", {31'd0, rd_miss}, 32'd0);
    start(2'd1);
    chk("b1_busy", {31'd0, rd_busy}, 32'd1);
    wait_last("last_b1");
    chk("clr_b13", {28'd0, bank_full}, 32'h0);
    tick();
    wait_idle();

    // Write into a full bank.
    load_length = 3'd3;
    fill(2'd0, 4, 32'h40);
    wr(2'd0, 3'd0, 32'hDEAD);
`ifdef FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN
    chk("ovf_set", {31'd0, error_overflow}, 32'd1);
    push(32'h40, 1'b0);
`else
    chk("ovf_set", {31'd0, error_overflow}, 32'd0);
    push(32'hDEAD, 1'b0);
`endif
    push(32'h41, 1'b0);
    push(32'h42, 1'b0);
    push(32'h43, 1'b1);
    tick();
    tick();
    start(2'd0);
    wait_last("last_ovf");
    tick();
    wait_idle();
`ifdef FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN
    chk("ovf_sticky", {31'd0, error_overflow}, 32'd1);
`else
    chk("ovf_sticky", {31'd0, error_overflow}, 32'd0);
`endif

    // Set and clear of bank 2 on the final address issue.
    fill(2'd2, 4, 32'h20);
    expect_bank(4, 32'h20);
    start(2'd2);
    tick();
    tick();
    tick();
    wr(2'd2, 3'd3, 32'h77);
    chk("sc_last", {31'd0, rd_last}, 32'd1);
`ifdef FULL_ST0_ERROR_BUF_OVERFLOW_CHECK_EN
    chk("set_wins", {28'd0, bank_full}, 32'h0);
    tick();
    wait_idle();
`else
    chk("set_wins", {28'd0, bank_full}, 32'h4);
    tick();
    wait_idle();
    push(32'h20, 1'b0);
    push(32'h21, 1'b0);
    push(32'h22, 1'b0);
    push(32'h77, 1'b1);
    start(2'd2);
    wait_last("last_b2b");
    tick();
    wait_idle();
`endif

    // Reset in the middle of a replay.
    load_length = 3'd7;
    fill(2'd1, 8, 32'h50);
    fill(2'd3, 8, 32'h60);
    push(32'h50, 1'b0);
    push(32'h51, 1'b0);
    push(32'h52, 1'b0);
    start(2'd1);
    tick();
    tick();
    tick();
    chk("third_vld", {31'd0, rd_vld}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_vld", {31'd0, rd_vld}, 32'd0);
    chk("rr_busy", {31'd0, rd_busy}, 32'd0);
    chk("rr_full", {28'd0, bank_full}, 32'h0);
    start(2'd3);
    chk("rr_miss", {31'd0, rd_miss}, 32'd1);
    tick();
    tick();
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
